// File: rtl/mips_defs.sv
// mips_defs: shared widths, ALU opcodes and the EX-stage register layout.
package mips_defs;
    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int OPW = 5;

    localparam logic [OPW-1:0] A_NOP  = 5'd0;
    localparam logic [OPW-1:0] A_ADD  = 5'd1;
    localparam logic [OPW-1:0] A_SUB  = 5'd2;
    localparam logic [OPW-1:0] A_AND  = 5'd3;
    localparam logic [OPW-1:0] A_OR   = 5'd4;
    localparam logic [OPW-1:0] A_XOR  = 5'd5;
    localparam logic [OPW-1:0] A_NOR  = 5'd6;
    localparam logic [OPW-1:0] A_SLT  = 5'd7;
    localparam logic [OPW-1:0] A_SLTU = 5'd8;
    localparam logic [OPW-1:0] A_SLL  = 5'd9;
    localparam logic [OPW-1:0] A_SRL  = 5'd10;
    localparam logic [OPW-1:0] A_SRA  = 5'd11;
    localparam logic [OPW-1:0] A_SLLV = 5'd12;
    localparam logic [OPW-1:0] A_SRLV = 5'd13;
    localparam logic [OPW-1:0] A_SRAV = 5'd14;
    localparam logic [OPW-1:0] A_LUI  = 5'd15;

    typedef struct packed {
        logic           valid;
        logic [DW-1:0]  pc;
        logic [RW-1:0]  rs_addr;
        logic [RW-1:0]  rt_addr;
        logic [DW-1:0]  rs_data;
        logic [DW-1:0]  rt_data;
        logic [DW-1:0]  imm;
        logic [4:0]     shamt;
        logic [RW-1:0]  waddr;
        logic [OPW-1:0] alu_op;
        logic           src_a_shamt;
        logic           src_b_imm;
        logic           reg_we;
        logic           mem_read;
    } ex_reg_t;

    // A bubble is all-zero: invalid, A_NOP, no side effects, no stored data.
    localparam ex_reg_t EX_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_if: ID-side inputs, forwarding sources and ALU-side outputs of the ID/EX stage.
interface id_ex_if;
    import mips_defs::*;
    logic           stall, flush;
    logic           id_valid;
    logic [DW-1:0]  id_pc;
    logic [RW-1:0]  id_rs_addr, id_rt_addr;
    logic [DW-1:0]  id_rs_data, id_rt_data, id_imm;
    logic [4:0]     id_shamt;
    logic [RW-1:0]  id_waddr;
    logic [OPW-1:0] id_alu_op;
    logic           id_src_a_shamt, id_src_b_imm, id_reg_we, id_mem_read;
    logic           id_uses_rs, id_uses_rt;
    logic           exmem_we, memwb_we;
    logic [RW-1:0]  exmem_waddr, memwb_waddr;
    logic [DW-1:0]  exmem_wdata, memwb_wdata;
    logic [DW-1:0]  alu_a, alu_b;
    logic [OPW-1:0] alu_op;
    logic           ex_valid, ex_reg_we, ex_mem_read;
    logic [DW-1:0]  ex_pc, ex_rt_fwd;
    logic [RW-1:0]  ex_waddr;
    logic           hazard_stall;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_waddr, id_alu_op, id_src_a_shamt, id_src_b_imm, id_reg_we,
               id_mem_read, id_uses_rs, id_uses_rt, exmem_we, exmem_waddr, exmem_wdata,
               memwb_we, memwb_waddr, memwb_wdata,
        input  alu_a, alu_b, alu_op, ex_valid, ex_pc, ex_waddr, ex_reg_we, ex_mem_read,
               ex_rt_fwd, hazard_stall
    );
    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs_addr, id_rt_addr, id_rs_data, id_rt_data,
               id_imm, id_shamt, id_waddr, id_alu_op, id_src_a_shamt, id_src_b_imm, id_reg_we,
               id_mem_read, id_uses_rs, id_uses_rt, exmem_we, exmem_waddr, exmem_wdata,
               memwb_we, memwb_waddr, memwb_wdata,
        output alu_a, alu_b, alu_op, ex_valid, ex_pc, ex_waddr, ex_reg_we, ex_mem_read,
               ex_rt_fwd, hazard_stall
    );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks the newest value of a register from EX/MEM, MEM/WB or the register file.
module fwd_mux
    import mips_defs::*;
(
    input  logic [RW-1:0] addr,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_we,
    input  logic [RW-1:0] exmem_waddr,
    input  logic [DW-1:0] exmem_wdata,
    input  logic          memwb_we,
    input  logic [RW-1:0] memwb_waddr,
    input  logic [DW-1:0] memwb_wdata,
    output logic [DW-1:0] data
);
    always_comb begin
        data = (addr == '0) ? '0 :
               (exmem_we && exmem_waddr == addr) ? exmem_wdata :
               (memwb_we && memwb_waddr == addr) ? memwb_wdata : reg_data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubble insertion.
module id_ex_stage
    import mips_defs::*;
(
    input logic    clk,
    input logic    rst,
    id_ex_if.slave bus
);
    ex_reg_t       ex_q, id_d;
    logic [DW-1:0] fwd_rs, fwd_rt;

    always_comb begin
        id_d = EX_BUBBLE;
        if (bus.id_valid)
            id_d = '{valid: 1'b1, pc: bus.id_pc, rs_addr: bus.id_rs_addr, rt_addr: bus.id_rt_addr,
                     rs_data: bus.id_rs_data, rt_data: bus.id_rt_data, imm: bus.id_imm,
                     shamt: bus.id_shamt, waddr: bus.id_waddr, alu_op: bus.id_alu_op,
                     src_a_shamt: bus.id_src_a_shamt, src_b_imm: bus.id_src_b_imm,
                     reg_we: bus.id_reg_we, mem_read: bus.id_mem_read};
    end

    assign bus.hazard_stall = !rst && !bus.flush && bus.id_valid && ex_q.valid && ex_q.mem_read &&
                              ex_q.waddr != '0 &&
                              ((bus.id_uses_rs && bus.id_rs_addr == ex_q.waddr) ||
                               (bus.id_uses_rt && bus.id_rt_addr == ex_q.waddr));

    always_ff @(posedge clk) begin
        if (rst || bus.flush)
            ex_q <= EX_BUBBLE;
        else if (!bus.stall)
            ex_q <= bus.hazard_stall ? EX_BUBBLE : id_d;
    end

    fwd_mux u_fwd_rs (
        .addr(ex_q.rs_addr), .reg_data(ex_q.rs_data),
        .exmem_we(bus.exmem_we), .exmem_waddr(bus.exmem_waddr), .exmem_wdata(bus.exmem_wdata),
        .memwb_we(bus.memwb_we), .memwb_waddr(bus.memwb_waddr), .memwb_wdata(bus.memwb_wdata),
        .data(fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .addr(ex_q.rt_addr), .reg_data(ex_q.rt_data),
        .exmem_we(bus.exmem_we), .exmem_waddr(bus.exmem_waddr), .exmem_wdata(bus.exmem_wdata),
        .memwb_we(bus.memwb_we), .memwb_waddr(bus.memwb_waddr), .memwb_wdata(bus.memwb_wdata),
        .data(fwd_rt)
    );

    assign bus.alu_a       = ex_q.src_a_shamt ? {{(DW-5){1'b0}}, ex_q.shamt} : fwd_rs;
    assign bus.alu_b       = ex_q.src_b_imm ? ex_q.imm : fwd_rt;
    assign bus.alu_op      = ex_q.alu_op;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_waddr    = ex_q.waddr;
    assign bus.ex_reg_we   = ex_q.reg_we;
    assign bus.ex_mem_read = ex_q.mem_read;
    assign bus.ex_rt_fwd   = fwd_rt;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers decoded operands and control from ID, then resolves data hazards by forwarding from EX/MEM and MEM/WB.
- Selects immediate or shift-amount sources and drives alu_a/alu_b/alu_op into the ALU.
- Detects load-use hazards, requests a front-end stall and inserts a bubble; supports external stall and flush.

Parameters:
- DW, 32, datapath width
- RW, 5, register address width
- OPW, 5, ALU opcode width (A_NOP=0 … A_LUI=15)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold EX register contents (downstream stall)
- flush  in  1  replace EX contents with bubble (branch/exception)
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DW  instruction PC
- id_rs_addr, id_rt_addr  in  RW  source register numbers
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  DW  already sign/zero-extended immediate
- id_shamt  in  5  shift amount
- id_waddr  in  RW  destination register
- id_alu_op  in  OPW  ALU opcode
- id_src_a_shamt  in  1  alu_a = zero-extended shamt
- id_src_b_imm  in  1  alu_b = immediate
- id_reg_we  in  1  writes register file
- id_mem_read  in  1  load instruction
- id_uses_rs, id_uses_rt  in  1  operand actually read
- exmem_we, exmem_waddr, exmem_wdata  in  1/RW/DW  EX/MEM forwarding source
- memwb_we, memwb_waddr, memwb_wdata  in  1/RW/DW  MEM/WB forwarding source
- alu_a, alu_b  out  DW  ALU operands
- alu_op  out  OPW  ALU opcode
- ex_valid, ex_pc, ex_waddr, ex_reg_we, ex_mem_read, ex_rt_fwd  out  1/DW/RW/1/1/DW  pass-through to EX/MEM; ex_rt_fwd is the forwarded rt (store data)
- hazard_stall  out  1  freeze PC and IF/ID this cycle

Behaviour:
- Register update priority each rising clk: rst > flush > stall > load-use bubble > load from ID.
- rst or flush: ex_valid=0, alu_op=A_NOP, ex_reg_we=0, ex_mem_read=0, ex_pc=0, ex_waddr=0. All stored data fields = 0.
- stall=1 (and no flush): every field holds.
- Load-use bubble, when hazard_stall=1 and stall=0: load bubble (same values as flush); ID is held externally.
- Otherwise: capture all id_* fields. If id_valid=0, store as bubble.
- hazard_stall is combinational:
  - asserted when ex_valid & ex_mem_read & ex_waddr≠0 & ((id_uses_rs & id_rs_addr==ex_waddr) | (id_uses_rt & id_rt_addr==ex_waddr)) & id_valid;
  - forced 0 during rst or flush.
- Forwarding is combinational on the registered rs/rt address, applied independently per operand:
  - addr==0 → 0;
  - else exmem_we & exmem_waddr==addr → exmem_wdata;
  - else memwb_we & memwb_waddr==addr → memwb_wdata;
  - else the registered data.
- EX/MEM source has priority over MEM/WB when both match.
- alu_a = src_a_shamt ? {27'b0,shamt} : fwd_rs.
- alu_b = src_b_imm ? imm : fwd_rt.
- ex_rt_fwd = fwd_rt, regardless of src_b_imm.
- Latency: ID inputs appear on outputs one cycle after capture. Forwarded values reach outputs in the same cycle.
- Register 0 is never forwarded, even when a writer targets it.
- Flush and load-use in the same cycle: flush wins and hazard_stall=0.
- Stall and load-use in the same cycle: EX holds and hazard_stall stays 1.
- All arithmetic is width DW, with no sign handling in this block.

Decomposition:
- Shared package mips_defs: A_* ALU opcode constants (A_NOP=0 … A_LUI=15), DW/RW widths, bubble-field defaults.
- One sub-module, fwd_mux: pure combinational 3-source forwarding selector, instantiated twice (rs, rt).

Test Plan:
- Reset: rst=1 for 2 cycles with id_valid=1 → ex_valid=0, alu_op=0, ex_reg_we=0, hazard_stall=0.
- Plain capture:
  - stimulus: id_alu_op=A_ADD(1), rs_data=2, rt_data=3, no forwarding;
  - response: next cycle alu_a=2, alu_b=3, alu_op=1.
- Forwarding priority:
  - stimulus: EX rs=r5, exmem (we=1, addr=5, data=0x11), memwb (we=1, addr=5, data=0x22);
  - response: alu_a=0x11. Drop exmem_we → alu_a=0x22. With rs=r0 and both writers on r0 → alu_a=0.
- Immediate/shamt:
  - A_LUI with src_b_imm=1, imm=0x0000ABCD → alu_b=0x0000ABCD;
  - A_SLL with src_a_shamt=1, shamt=7 → alu_a=7.
- Load-use:
  - stimulus: EX holds load to r8, ID uses rs=r8;
  - response: hazard_stall=1. Next cycle is a bubble (alu_op=0, ex_valid=0) and hazard_stall=0.
- Stall/flush:
  - stall=1 for 3 cycles → outputs frozen;
  - flush=1 concurrent with stall → bubble loaded next cycle.
